// File: rtl/stat_seq_bench.sv
// Sequential benchmark core: registered chi/rotate mixing pipeline,
// optional output-state feedback, and a Galois MISR with vector counter.
module stat_seq_bench #(
  parameter int                 WIDTH  = 32,
  parameter int                 STAGES = 2,
  parameter logic [WIDTH-1:0]   POLY   = WIDTH'(32'h04C11DB7),
  parameter int                 CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             fb_en,
  input  logic             sig_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] sig,
  output logic [CNT_W-1:0] vec_cnt
);

  function automatic logic [WIDTH-1:0] chi(
    input logic [WIDTH-1:0] x
  );
    logic [WIDTH-1:0] y;
    y = '0;
    for (int i = 0; i < WIDTH; i++)
      y[i] = x[i] ^ (~x[(i+1)%WIDTH] & x[(i+2)%WIDTH]);
    return y;
  endfunction

  function automatic logic [WIDTH-1:0] rotl(
    input logic [WIDTH-1:0] x,
    input int               k
  );
    logic [WIDTH-1:0] y;
    y = '0;
    for (int i = 0; i < WIDTH; i++)
      y[(i+k)%WIDTH] = x[i];
    return y;
  endfunction

  logic [WIDTH-1:0] s [STAGES+1];
  logic [STAGES:0]  v;
  logic [WIDTH-1:0] state;

  assign out_data  = s[STAGES];
  assign out_valid = v[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= STAGES; k++)
        s[k] <= '0;
      v <= '0;
    end else begin
      v <= {v[STAGES-1:0], in_valid};
      if (in_valid)
        s[0] <= in_data ^ (fb_en ? state : '0);
      for (int k = 1; k <= STAGES; k++)
        s[k] <= rotl(chi(s[k-1]), k);
    end
  end

  // clear is applied before the fold of a coincident output
  logic [WIDTH-1:0] sig_base;
  logic [WIDTH-1:0] sig_next;
  logic [CNT_W-1:0] cnt_base;

  always_comb begin
    sig_base = sig_clr ? '0 : sig;
    cnt_base = sig_clr ? '0 : vec_cnt;
    sig_next = {sig_base[WIDTH-2:0], 1'b0}
             ^ (sig_base[WIDTH-1] ? POLY : '0)
             ^ out_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= '0;
      sig     <= '0;
      vec_cnt <= '0;
    end else if (out_valid) begin
      state <= out_data;
      sig   <= sig_next;
      if (cnt_base != '1)
        vec_cnt <= cnt_base + CNT_W'(1);
      else
        vec_cnt <= cnt_base;
    end else if (sig_clr) begin
      sig     <= '0;
      vec_cnt <= '0;
    end
  end

endmodule
